// File: rtl/note_glyph_gen.sv
// note_glyph_gen: renders a note code as three 8x16 text glyphs ("L1 ", "---", ...).
// The lines are built one byte per cycle in a shadow buffer and committed atomically.
// Optional feature: define NOTE_GLYPH_SHARP_EN to show '#' in slot 2 for sharp notes.
module note_glyph_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        note_valid,
    input  logic [4:0]  note_code,
    input  logic        note_sharp,
    output logic        busy,
    output logic        done,
    output logic [23:0] char_line0,
    output logic [23:0] char_line1,
    output logic [23:0] char_line2,
    output logic [23:0] char_line3,
    output logic [23:0] char_line4,
    output logic [23:0] char_line5,
    output logic [23:0] char_line6,
    output logic [23:0] char_line7,
    output logic [23:0] char_line8,
    output logic [23:0] char_line9,
    output logic [23:0] char_linea,
    output logic [23:0] char_lineb,
    output logic [23:0] char_linec,
    output logic [23:0] char_lined,
    output logic [23:0] char_linee,
    output logic [23:0] char_linef
);

    typedef enum logic [1:0] {StIdle, StBuild, StCommit} state_e;
    typedef enum logic [3:0] {
        GSpace, GDash, GL, GM, GH, GD1, GD2, GD3, GD4, GD5, GD6, GD7, GSharp
    } glyph_e;

    // Bitmaps for glyph rows 3..13, row 3 in the top byte.
    localparam logic [87:0] BmpDash = 88'h00_00_00_00_00_7E_00_00_00_00_00;
    localparam logic [87:0] BmpL    = 88'hF0_60_60_60_60_60_60_60_62_66_FE;
    localparam logic [87:0] BmpM    = 88'hC3_E7_FF_DB_C3_C3_C3_C3_C3_C3_C3;
    localparam logic [87:0] BmpH    = 88'hF7_63_63_63_63_7F_63_63_63_63_F7;
    localparam logic [87:0] Bmp1    = 88'h18_78_18_18_18_18_18_18_18_18_7E;
    localparam logic [87:0] Bmp2    = 88'h3C_66_06_0C_18_30_60_60_60_66_7E;
    localparam logic [87:0] Bmp3    = 88'h3C_66_06_06_1C_06_06_06_06_66_3C;
    localparam logic [87:0] Bmp4    = 88'h0C_1C_3C_6C_CC_FE_0C_0C_0C_0C_1E;
    localparam logic [87:0] Bmp5    = 88'h7E_60_60_60_7C_06_06_06_06_66_3C;
    localparam logic [87:0] Bmp6    = 88'h3C_66_60_60_7C_66_66_66_66_66_3C;
    localparam logic [87:0] Bmp7    = 88'h7E_66_06_0C_18_18_18_18_18_18_18;
`ifdef NOTE_GLYPH_SHARP_EN
    localparam logic [87:0] BmpSharp = 88'h00_24_24_7E_24_24_24_7E_24_24_00;
`endif

    function automatic logic [7:0] glyph_row(input glyph_e g, input logic [3:0] row);
        logic [87:0] bmp;
        logic [3:0]  idx;
        logic [6:0]  sh;
        case (g)
            GDash:   bmp = BmpDash;
            GL:      bmp = BmpL;
            GM:      bmp = BmpM;
            GH:      bmp = BmpH;
            GD1:     bmp = Bmp1;
            GD2:     bmp = Bmp2;
            GD3:     bmp = Bmp3;
            GD4:     bmp = Bmp4;
            GD5:     bmp = Bmp5;
            GD6:     bmp = Bmp6;
            GD7:     bmp = Bmp7;
`ifdef NOTE_GLYPH_SHARP_EN
            GSharp:  bmp = BmpSharp;
`endif
            default: bmp = '0;
        endcase
        if (row < 4'd3 || row > 4'd13) begin
            return 8'h00;
        end
        idx = row - 4'd3;
        sh  = 7'(8 * (4'd10 - idx));
        return bmp[sh +: 8];
    endfunction

    state_e      r_state;
    logic [4:0]  r_code;
    logic        r_sharp;
    logic        r_pend_vld;
    logic [4:0]  r_pend_code;
    logic        r_pend_sharp;
    logic [3:0]  r_row;
    logic [1:0]  r_slot;
    logic        r_busy;
    logic        r_done;
    logic [23:0] r_shadow [16];
    logic [23:0] r_line   [16];

    logic        w_sharp_in;
    logic [4:0]  w_c;
    logic [2:0]  w_d;
    glyph_e      w_slot_g [3];
    glyph_e      w_glyph;
    logic [7:0]  w_byte;

`ifdef NOTE_GLYPH_SHARP_EN
    assign w_sharp_in = note_sharp;
`else
    logic w_unused_sharp;
    assign w_unused_sharp = note_sharp;
    assign w_sharp_in     = 1'b0;
`endif

    // Decode the latched note into three glyph ids and pick the byte for this build step.
    always_comb begin
        w_c         = r_code - 5'd1;
        w_d         = 3'd0;
        w_slot_g[0] = GSpace;
        w_slot_g[1] = GSpace;
        w_slot_g[2] = GSpace;
        if (r_code == 5'd0) begin
            w_slot_g[0] = GDash;
            w_slot_g[1] = GDash;
            w_slot_g[2] = GDash;
        end else if (r_code <= 5'd21) begin
            if (w_c < 5'd7) begin
                w_slot_g[0] = GL;
                w_d         = w_c[2:0];
            end else if (w_c < 5'd14) begin
                w_slot_g[0] = GM;
                w_d         = 3'(w_c - 5'd7);
            end else begin
                w_slot_g[0] = GH;
                w_d         = 3'(w_c - 5'd14);
            end
            w_slot_g[1] = glyph_e'(4'(GD1) + 4'(w_d));
`ifdef NOTE_GLYPH_SHARP_EN
            if (r_sharp) begin
                w_slot_g[2] = GSharp;
            end
`endif
        end
        w_glyph = (r_slot == 2'd0) ? w_slot_g[0] :
                  (r_slot == 2'd1) ? w_slot_g[1] : w_slot_g[2];
        w_byte  = glyph_row(w_glyph, r_row);
    end

    // Control FSM, pending request, shadow build and atomic commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_code       <= 5'd0;
            r_sharp      <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_pend_code  <= 5'd0;
            r_pend_sharp <= 1'b0;
            r_row        <= 4'd0;
            r_slot       <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= 24'h0;
                r_line[i]   <= 24'h0;
            end
        end else begin
            r_done <= 1'b0;
            // Stays high through the done cycle, drops once back in idle with nothing queued.
            r_busy <= (r_state != StIdle) || note_valid || r_pend_vld;
            case (r_state)
                StIdle: begin
                    r_row  <= 4'd0;
                    r_slot <= 2'd0;
                    if (note_valid) begin
                        // A fresh request beats a queued one; the queued one is dropped.
                        r_code     <= note_code;
                        r_sharp    <= w_sharp_in;
                        r_pend_vld <= 1'b0;
                        r_state    <= StBuild;
                    end else if (r_pend_vld) begin
                        r_code     <= r_pend_code;
                        r_sharp    <= r_pend_sharp;
                        r_pend_vld <= 1'b0;
                        r_state    <= StBuild;
                    end
                end
                StBuild: begin
                    case (r_slot)
                        2'd0:    r_shadow[r_row][23:16] <= w_byte;
                        2'd1:    r_shadow[r_row][15:8]  <= w_byte;
                        default: r_shadow[r_row][7:0]   <= w_byte;
                    endcase
                    if (r_slot == 2'd2) begin
                        r_slot <= 2'd0;
                        r_row  <= r_row + 4'd1;
                        if (r_row == 4'd15) begin
                            r_state <= StCommit;
                        end
                    end else begin
                        r_slot <= r_slot + 2'd1;
                    end
                end
                StCommit: begin
                    for (int i = 0; i < 16; i++) begin
                        r_line[i] <= r_shadow[i];
                    end
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
            if (r_state != StIdle && note_valid) begin
                r_pend_vld   <= 1'b1;
                r_pend_code  <= note_code;
                r_pend_sharp <= w_sharp_in;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign char_line0 = r_line[0];
    assign char_line1 = r_line[1];
    assign char_line2 = r_line[2];
    assign char_line3 = r_line[3];
    assign char_line4 = r_line[4];
    assign char_line5 = r_line[5];
    assign char_line6 = r_line[6];
    assign char_line7 = r_line[7];
    assign char_line8 = r_line[8];
    assign char_line9 = r_line[9];
    assign char_linea = r_line[10];
    assign char_lineb = r_line[11];
    assign char_linec = r_line[12];
    assign char_lined = r_line[13];
    assign char_linee = r_line[14];
    assign char_linef = r_line[15];

endmodule

// File: tb/tb_note_glyph_gen.sv
// Directed testbench for note_glyph_gen with hand-computed glyph lines.
module tb_note_glyph_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        note_valid;
    logic [4:0]  note_code;
    logic        note_sharp;
    logic        busy;
    logic        done;
    logic [23:0] line [16];

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int done_cnt = 0;
    int done_cyc_last = 0;
    int done_cyc_prev = 0;
    logic [23:0] snap_last [16];
    logic [23:0] snap_prev [16];

    note_glyph_gen u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_valid (note_valid),
        .note_code  (note_code),
        .note_sharp (note_sharp),
        .busy       (busy),
        .done       (done),
        .char_line0 (line[0]),
        .char_line1 (line[1]),
        .char_line2 (line[2]),
        .char_line3 (line[3]),
        .char_line4 (line[4]),
        .char_line5 (line[5]),
        .char_line6 (line[6]),
        .char_line7 (line[7]),
        .char_line8 (line[8]),
        .char_line9 (line[9]),
        .char_linea (line[10]),
        .char_lineb (line[11]),
        .char_linec (line[12]),
        .char_lined (line[13]),
        .char_linee (line[14]),
        .char_linef (line[15])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Record every done pulse with the lines it committed.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc_prev = done_cyc_last;
            done_cyc_last = cycle;
            for (int i = 0; i < 16; i++) begin
                snap_prev[i] = snap_last[i];
                snap_last[i] = line[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Present one request for exactly one rising edge.
    task automatic send(input logic [4:0] code, input logic sharp);
        @(negedge clk);
        note_valid = 1'b1;
        note_code  = code;
        note_sharp = sharp;
        @(negedge clk);
        note_valid = 1'b0;
    endtask

    // Count edges from acceptance until done is seen; bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    logic [23:0] exp15 [16];
    int          lat;
    int          base;

    initial begin
        exp15 = '{24'h0, 24'h0, 24'h0, 24'hF71800, 24'h637800, 24'h631800, 24'h631800,
                  24'h631800, 24'h7F1800, 24'h631800, 24'h631800, 24'h631800, 24'h631800,
                  24'hF77E00, 24'h0, 24'h0};
        rst_n      = 1'b0;
        note_valid = 1'b0;
        note_code  = 5'd0;
        note_sharp = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_line8", 32'(line[8]), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // code 15 -> "H1 "
        send(5'd15, 1'b0);
        check("c15_busy_build", 32'(busy), 32'd1);
        check("c15_line3_held", 32'(line[3]), 32'h0);
        wait_done(lat);
        check("c15_latency", 32'(lat), 32'd49);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("c15_line%0d", i), 32'(line[i]), 32'(exp15[i]));
        end

        // code 0 -> "---"
        repeat (3) @(negedge clk);
        send(5'd0, 1'b0);
        wait_done(lat);
        check("c0_latency", 32'(lat), 32'd49);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("c0_line%0d", i), 32'(line[i]), (i == 8) ? 32'h7E7E7E : 32'h0);
        end

        // code 1, then 15 at +10 and 0 at +20 while busy: 15 is overwritten
        repeat (3) @(negedge clk);
        base = done_cnt;
        send(5'd1, 1'b0);
        repeat (8) @(negedge clk);
        send(5'd15, 1'b0);
        check("seq_busy_pending", 32'(busy), 32'd1);
        repeat (8) @(negedge clk);
        send(5'd0, 1'b0);
        repeat (150) @(negedge clk);
        check("seq_done_count", 32'(done_cnt - base), 32'd2);
        check("seq_first_line3", 32'(snap_prev[3]), 32'hF01800);
        check("seq_first_line8", 32'(snap_prev[8]), 32'h601800);
        check("seq_first_line13", 32'(snap_prev[13]), 32'hFE7E00);
        check("seq_second_line8", 32'(snap_last[8]), 32'h7E7E7E);
        check("seq_second_line3", 32'(snap_last[3]), 32'h0);
        check("seq_gap", 32'(done_cyc_last - done_cyc_prev), 32'd50);
        check("seq_idle_busy", 32'(busy), 32'd0);

        // reset at build cycle 20 aborts the render
        base = done_cnt;
        send(5'd15, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_line8", 32'(line[8]), 32'h0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("rstmid_no_done", 32'(done_cnt - base), 32'd0);
        check("rstmid_line3", 32'(line[3]), 32'h0);
        send(5'd7, 1'b0);
        wait_done(lat);
        check("c7_latency", 32'(lat), 32'd49);
        check("c7_line3", 32'(line[3]), 32'hF07E00);
        check("c7_line9", 32'(line[9]), 32'h601800);
        check("c7_line14", 32'(line[14]), 32'h0);

        // code 25 (invalid) -> all spaces
        repeat (3) @(negedge clk);
        base = done_cnt;
        send(5'd25, 1'b0);
        wait_done(lat);
        check("c25_latency", 32'(lat), 32'd49);
        check("c25_busy_at_done", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("c25_line%0d", i), 32'(line[i]), 32'h0);
        end
        @(negedge clk);
        check("c25_busy_after", 32'(busy), 32'd0);
        check("c25_done_pulse", 32'(done), 32'd0);
        repeat (10) @(negedge clk);
        check("c25_done_once", 32'(done_cnt - base), 32'd1);

        // code 8 with sharp -> "M1#" or "M1 "
        send(5'd8, 1'b1);
        wait_done(lat);
        check("c8_latency", 32'(lat), 32'd49);
`ifdef NOTE_GLYPH_SHARP_EN
        check("c8_line3", 32'(line[3]), 32'hC31800);
        check("c8_line6", 32'(line[6]), 32'hDB187E);
        check("c8_line10", 32'(line[10]), 32'hC3187E);
`else
        check("c8_line3", 32'(line[3]), 32'hC31800);
        check("c8_line6", 32'(line[6]), 32'hDB1800);
        check("c8_line10", 32'(line[10]), 32'hC31800);
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
